// File: rtl/out_port_fifo_if.sv
// Handshake bundle between the CPU output port, the output FIFO and its downstream consumer.
// The slave modport is the FIFO's view; the master modport is the producer/consumer side.
interface out_port_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic              out_signal;
  logic [DATA_W-1:0] out_data;
  logic              cpu_halt;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [CW-1:0]     count;
  logic              full;
  logic              overflow;
  logic              drained;

  modport slave (
    input  out_signal, out_data, cpu_halt, m_ready,
    output m_valid, m_data, count, full, overflow, drained
  );

  modport master (
    output out_signal, out_data, cpu_halt, m_ready,
    input  m_valid, m_data, count, full, overflow, drained
  );
endinterface

// File: rtl/out_port_fifo.sv
// Output-port FIFO: buffers CPU out_signal/out_data writes and drains them over valid/ready.
// Define OUT_PORT_FIFO_EDGE_EN to push once per rising edge of out_signal instead of every high cycle.
module out_port_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  out_port_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_drained;

  logic              w_push_req;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CW-1:0]     w_count_next;

`ifdef OUT_PORT_FIFO_EDGE_EN
  logic r_sig_q;

  always_ff @(posedge clk) begin
    if (!reset) r_sig_q <= 1'b0;
    else        r_sig_q <= bus.out_signal;
  end

  assign w_push_req = bus.out_signal && !r_sig_q;
`else
  assign w_push_req = bus.out_signal;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = !w_empty && bus.m_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_drop  = w_push_req && w_full && !w_pop;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drained  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_count_next;
      if (w_drop) r_overflow <= 1'b1;
      r_drained <= bus.cpu_halt && (w_count_next == '0);
    end
  end

  // Storage carries no reset; stale words are masked by count on the output.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_mem[r_wr_ptr] <= bus.out_data;
  end

  assign bus.m_valid  = !w_empty;
  assign bus.m_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.overflow = r_overflow;
  assign bus.drained  = r_drained;
endmodule

// File: tb/tb_out_port_fifo.sv
// Scoreboard bench for out_port_fifo: expected words queue up as pushes are driven and are
// compared when the consumer takes them; status outputs are compared after every clock.
module tb_out_port_fifo;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  out_port_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  out_port_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_popped = 0;

  logic [DATA_W-1:0] exp_q[$];
  bit                mdl_ovf   = 1'b0;
  bit                mdl_drn   = 1'b0;
  bit                mdl_sig_q = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: update the model with the inputs as driven, then compare outputs.
  task automatic step();
    bit pop;
    bit push_req;
    bit was_full;
    pop = 1'b0;
    if (!reset) begin
      exp_q.delete();
      mdl_ovf   = 1'b0;
      mdl_drn   = 1'b0;
      mdl_sig_q = 1'b0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      if (bus.m_ready && exp_q.size() != 0) begin
        check("pop_data", bus.m_data, exp_q[0]);
        void'(exp_q.pop_front());
        pop = 1'b1;
        n_popped++;
      end
`ifdef OUT_PORT_FIFO_EDGE_EN
      push_req = bus.out_signal && !mdl_sig_q;
`else
      push_req = bus.out_signal;
`endif
      mdl_sig_q = bus.out_signal;
      if (push_req) begin
        if (!was_full || pop) exp_q.push_back(bus.out_data);
        else                  mdl_ovf = 1'b1;
      end
      mdl_drn = bus.cpu_halt && (exp_q.size() == 0);
    end
    @(posedge clk);
    #1;
    check("count",    64'(bus.count),    64'(exp_q.size()));
    check("m_valid",  64'(bus.m_valid),  64'(exp_q.size() != 0));
    check("m_data",   bus.m_data,        (exp_q.size() != 0) ? exp_q[0] : 64'h0);
    check("full",     64'(bus.full),     64'(exp_q.size() == DEPTH));
    check("overflow", 64'(bus.overflow), 64'(mdl_ovf));
    check("drained",  64'(bus.drained),  64'(mdl_drn));
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    bus.out_signal = 1'b1;
    bus.out_data   = d;
    step();
    bus.out_signal = 1'b0;
    step();
  endtask

  initial begin
    int base;
    int exp_n;
    bus.out_signal = 1'b0;
    bus.out_data   = '0;
    bus.cpu_halt   = 1'b0;
    bus.m_ready    = 1'b0;

    // Reset state
    reset = 1'b0;
    step();
    step();
    check("rst_count",   64'(bus.count),    64'd0);
    check("rst_m_valid", 64'(bus.m_valid),  64'd0);
    check("rst_m_data",  bus.m_data,        64'd0);
    check("rst_ovf",     64'(bus.overflow), 64'd0);
    reset = 1'b1;
    step();

    // Single word, one-cycle latency, then consumed
    bus.out_signal = 1'b1;
    bus.out_data   = 64'h2A;
    step();
    bus.out_signal = 1'b0;
    check("single_valid", 64'(bus.m_valid), 64'd1);
    check("single_data",  bus.m_data,       64'h2A);
    check("single_count", 64'(bus.count),   64'd1);
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    check("single_empty", 64'(bus.m_valid), 64'd0);
    check("single_cnt0",  64'(bus.count),   64'd0);
    step();

    // Fill past capacity: word 8 dropped, overflow sticky
    for (int i = 0; i <= 8; i++) push_word(64'(i));
    check("fill_count", 64'(bus.count),    64'd8);
    check("fill_full",  64'(bus.full),     64'd1);
    check("fill_ovf",   64'(bus.overflow), 64'd1);
    bus.m_ready = 1'b1;
    base = n_popped;
    repeat (10) step();
    bus.m_ready = 1'b0;
    check("fill_drained_n", 64'(n_popped - base), 64'd8);
    check("fill_ovf_sticky", 64'(bus.overflow), 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_word(64'(i));
    bus.m_ready    = 1'b1;
    bus.out_signal = 1'b1;
    bus.out_data   = 64'h99;
    step();
    bus.out_signal = 1'b0;
    check("fullpp_count", 64'(bus.count),    64'd8);
    check("fullpp_ovf",   64'(bus.overflow), 64'd0);
    check("fullpp_head",  bus.m_data,        64'd1);
    repeat (9) step();
    bus.m_ready = 1'b0;
    check("fullpp_empty", 64'(bus.m_valid), 64'd0);

    // Wrap-around with at most three outstanding words
    base = n_popped;
    for (int i = 0; i < 20; i++) begin
      push_word(64'h100 + 64'(i));
      if ((i % 3) == 2) begin
        bus.m_ready = 1'b1;
        repeat (3) step();
        bus.m_ready = 1'b0;
      end
    end
    bus.m_ready = 1'b1;
    repeat (4) step();
    bus.m_ready = 1'b0;
    check("wrap_popped", 64'(n_popped - base), 64'd20);
    check("wrap_ovf",    64'(bus.overflow),    64'd0);

    // Strobe held high for three cycles
`ifdef OUT_PORT_FIFO_EDGE_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    for (int i = 5; i <= 7; i++) begin
      bus.out_signal = 1'b1;
      bus.out_data   = 64'(i);
      step();
    end
    bus.out_signal = 1'b0;
    step();
    check("strobe_count", 64'(bus.count), 64'(exp_n));
    check("strobe_head",  bus.m_data,     64'd5);
    bus.m_ready = 1'b1;
    repeat (4) step();
    bus.m_ready = 1'b0;

    // Halt and drain, then reset mid-drain
    for (int i = 0; i < 3; i++) push_word(64'h300 + 64'(i));
    bus.cpu_halt = 1'b1;
    step();
    check("halt_drn0", 64'(bus.drained), 64'd0);
    bus.m_ready = 1'b1;
    step();
    check("halt_drn1", 64'(bus.drained), 64'd0);
    step();
    check("halt_drn2", 64'(bus.drained), 64'd0);
    step();
    check("halt_drn3", 64'(bus.drained), 64'd1);
    bus.m_ready = 1'b0;
    push_word(64'h400);
    push_word(64'h401);
    check("refill_count", 64'(bus.count),   64'd2);
    check("refill_drn",   64'(bus.drained), 64'd0);
    bus.m_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("midrst_count", 64'(bus.count),    64'd0);
    check("midrst_valid", 64'(bus.m_valid),  64'd0);
    check("midrst_ovf",   64'(bus.overflow), 64'd0);
    check("midrst_drn",   64'(bus.drained),  64'd0);
    reset = 1'b1;
    step();
    check("post_rst_drn", 64'(bus.drained), 64'd1);
    bus.cpu_halt = 1'b0;
    step();
    check("unhalt_drn", 64'(bus.drained), 64'd0);
    repeat (3) step();
    check("post_rst_valid", 64'(bus.m_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
